// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID opcode into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, with load-use bubbles and a multi-cycle multiply hold.
module pipe_control #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       Op_i,
    input  logic             Mul_i,
    input  logic             NoOp_i,
    input  logic [REG_W-1:0] Rs1Addr_i,
    input  logic [REG_W-1:0] Rs2Addr_i,
    input  logic [REG_W-1:0] RdAddr_i,
    output logic             Branch_o,
    output logic             Stall_o,
    output logic             Busy_o,
    output logic [2:0]       EX_ALUOp_o,
    output logic             EX_ALUSrc_o,
    output logic             EX_Mul_o,
    output logic [REG_W-1:0] EX_RdAddr_o,
    output logic             MEM_MemRead_o,
    output logic             MEM_MemWrite_o,
    output logic             MEM_RegWrite_o,
    output logic [REG_W-1:0] MEM_RdAddr_o,
    output logic             WB_RegWrite_o,
    output logic             WB_MemtoReg_o,
    output logic [REG_W-1:0] WB_RdAddr_o
);

    localparam int CNT_W = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef struct packed {
        logic [2:0]       alu_op;
        logic             alu_src;
        logic             mul;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

    id_ex_t           id_bundle;
    id_ex_t           id_ex_reg;
    ex_mem_t          ex_mem_reg;
    mem_wb_t          mem_wb_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             load_use;
    logic             unused_op_low;

    // Only the upper opcode bits select the control class.
    assign unused_op_low = ^Op_i[3:0];

    always_comb begin
        id_bundle = '0;
        if (!NoOp_i) begin
            id_bundle.alu_op     = Op_i[6:4];
            id_bundle.alu_src    = ~Op_i[5] | ~Op_i[4];
            id_bundle.mul        = Mul_i & (Op_i[6:4] == 3'b011);
            id_bundle.mem_read   = ~Op_i[5] & ~Op_i[4];
            id_bundle.mem_write  = ~Op_i[6] & Op_i[5] & ~Op_i[4];
            id_bundle.reg_write  = ~Op_i[5] | Op_i[4];
            id_bundle.mem_to_reg = ~Op_i[5] & ~Op_i[4];
            id_bundle.rd         = RdAddr_i;
        end
    end

    assign Branch_o = ~NoOp_i & Op_i[6];

    assign load_use = id_ex_reg.mem_read && (id_ex_reg.rd != '0) &&
                      ((id_ex_reg.rd == Rs1Addr_i) || (id_ex_reg.rd == Rs2Addr_i));
    assign Stall_o  = load_use & ~NoOp_i;
    assign Busy_o   = id_ex_reg.mul & (cnt_reg != CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id_ex_reg  <= '0;
            ex_mem_reg <= '0;
            mem_wb_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            mem_wb_reg.reg_write  <= ex_mem_reg.reg_write;
            mem_wb_reg.mem_to_reg <= ex_mem_reg.mem_to_reg;
            mem_wb_reg.rd         <= ex_mem_reg.rd;
            if (Busy_o) begin
                // Multiply stays in EX; downstream drains behind a bubble.
                ex_mem_reg <= '0;
                cnt_reg    <= cnt_reg + 1'b1;
            end else begin
                ex_mem_reg.mem_read   <= id_ex_reg.mem_read;
                ex_mem_reg.mem_write  <= id_ex_reg.mem_write;
                ex_mem_reg.reg_write  <= id_ex_reg.reg_write;
                ex_mem_reg.mem_to_reg <= id_ex_reg.mem_to_reg;
                ex_mem_reg.rd         <= id_ex_reg.rd;
                cnt_reg               <= '0;
                if (Stall_o) begin
                    id_ex_reg <= '0;
                end else begin
                    id_ex_reg <= id_bundle;
                end
            end
        end
    end

    assign EX_ALUOp_o     = id_ex_reg.alu_op;
    assign EX_ALUSrc_o    = id_ex_reg.alu_src;
    assign EX_Mul_o       = id_ex_reg.mul;
    assign EX_RdAddr_o    = id_ex_reg.rd;
    assign MEM_MemRead_o  = ex_mem_reg.mem_read;
    assign MEM_MemWrite_o = ex_mem_reg.mem_write;
    assign MEM_RegWrite_o = ex_mem_reg.reg_write;
    assign MEM_RdAddr_o   = ex_mem_reg.rd;
    assign WB_RegWrite_o  = mem_wb_reg.reg_write;
    assign WB_MemtoReg_o  = mem_wb_reg.mem_to_reg;
    assign WB_RdAddr_o    = mem_wb_reg.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: two instances (MUL_LAT 4 and 1) driven by the same directed
// and random ID stream, each compared against a stage-shifting reference model.
module tb_pipe_control;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] op = '0;
    logic       mul = 1'b0;
    logic       noop = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

    logic [1:0] branch_w, stall_w, busy_w, ex_src_w, ex_mul_w;
    logic [1:0] mem_mr_w, mem_mw_w, mem_rw_w, wb_rw_w, wb_m2r_w;
    logic [2:0] ex_op_w [2];
    logic [4:0] ex_rd_w [2];
    logic [4:0] mem_rd_w [2];
    logic [4:0] wb_rd_w [2];

    always #5 clk_i = ~clk_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pipe_control #(.MUL_LAT((gi == 0) ? 4 : 1), .REG_W(5)) u_dut (
            .clk_i(clk_i), .rst_i(rst_i), .Op_i(op), .Mul_i(mul), .NoOp_i(noop),
            .Rs1Addr_i(rs1), .Rs2Addr_i(rs2), .RdAddr_i(rd),
            .Branch_o(branch_w[gi]), .Stall_o(stall_w[gi]), .Busy_o(busy_w[gi]),
            .EX_ALUOp_o(ex_op_w[gi]), .EX_ALUSrc_o(ex_src_w[gi]), .EX_Mul_o(ex_mul_w[gi]),
            .EX_RdAddr_o(ex_rd_w[gi]),
            .MEM_MemRead_o(mem_mr_w[gi]), .MEM_MemWrite_o(mem_mw_w[gi]),
            .MEM_RegWrite_o(mem_rw_w[gi]), .MEM_RdAddr_o(mem_rd_w[gi]),
            .WB_RegWrite_o(wb_rw_w[gi]), .WB_MemtoReg_o(wb_m2r_w[gi]), .WB_RdAddr_o(wb_rd_w[gi])
        );
    end

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src, is_mul, mem_read, mem_write, reg_write, mem_to_reg;
        logic [4:0] rd;
    } bnd_t;

    // Reference model: full bundles per stage plus remaining multiply hold cycles.
    bnd_t m_ex [2];
    bnd_t m_mem [2];
    bnd_t m_wb [2];
    int   m_rem [2];
    int   lat [2] = '{4, 1};

    int vectors = 0;
    int errs = 0;
    int busy_cnt [2] = '{0, 0};
    int stall_cnt = 0;

    function automatic bnd_t decode(input logic [6:0] o, input logic mu, input logic nop,
                                    input logic [4:0] d);
        bnd_t b = '0;
        if (!nop) begin
            b.alu_op     = o[6:4];
            b.alu_src    = ~o[5] | ~o[4];
            b.is_mul     = mu && (o[6:4] == 3'b011);
            b.mem_read   = ~o[5] & ~o[4];
            b.mem_write  = ~o[6] & o[5] & ~o[4];
            b.reg_write  = ~o[5] | o[4];
            b.mem_to_reg = b.mem_read;
            b.rd         = d;
        end
        return b;
    endfunction

    function automatic logic m_busy(input int k);
        return m_ex[k].is_mul && (m_rem[k] > 0);
    endfunction

    function automatic logic m_stall(input int k);
        return m_ex[k].mem_read && (m_ex[k].rd != 0) &&
               ((m_ex[k].rd == rs1) || (m_ex[k].rd == rs2)) && !noop;
    endfunction

    function automatic logic [31:0] model_regs(input int k);
        return {7'd0, m_ex[k].alu_op, m_ex[k].alu_src, m_ex[k].is_mul, m_ex[k].rd,
                m_mem[k].mem_read, m_mem[k].mem_write, m_mem[k].reg_write, m_mem[k].rd,
                m_wb[k].reg_write, m_wb[k].mem_to_reg, m_wb[k].rd};
    endfunction

    function automatic logic [31:0] dut_regs(input int k);
        return {7'd0, ex_op_w[k], ex_src_w[k], ex_mul_w[k], ex_rd_w[k],
                mem_mr_w[k], mem_mw_w[k], mem_rw_w[k], mem_rd_w[k],
                wb_rw_w[k], wb_m2r_w[k], wb_rd_w[k]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_rem[k] = 0;
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_regs_lat%0d", tag, lat[k]), dut_regs(k), model_regs(k));
        end
    endtask

    task automatic step(input logic [6:0] o, input logic mu, input logic nop,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        bnd_t id;
        logic bz [2];
        logic st [2];
        op = o; mul = mu; noop = nop; rs1 = a1; rs2 = a2; rd = d;
        #1;
        id = decode(o, mu, nop, d);
        for (int k = 0; k < 2; k++) begin
            bz[k] = m_busy(k);
            st[k] = m_stall(k);
            chk($sformatf("branch_lat%0d", lat[k]), {31'd0, branch_w[k]}, {31'd0, ~nop & o[6]});
            chk($sformatf("stall_lat%0d", lat[k]), {31'd0, stall_w[k]}, {31'd0, st[k]});
            chk($sformatf("busy_lat%0d", lat[k]), {31'd0, busy_w[k]}, {31'd0, bz[k]});
            busy_cnt[k] += int'(busy_w[k]);
        end
        stall_cnt += int'(stall_w[0]);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_wb[k] = m_mem[k];
            if (bz[k]) begin
                m_mem[k] = '0;
                m_rem[k]--;
            end else begin
                m_mem[k] = m_ex[k];
                m_ex[k]  = st[k] ? bnd_t'('0) : id;
                m_rem[k] = m_ex[k].is_mul ? lat[k] - 1 : 0;
            end
        end
        check_all_regs("edge");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'h00, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    endtask

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_I  = 7'b0010011;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [5];
        ops = '{OP_R, OP_LD, OP_ST, OP_BR, OP_I};
        model_reset();
        op = OP_R; rs1 = 5'd1; rs2 = 5'd1;
        #3;
        check_all_regs("in_reset");
        chk("reset_busy", {30'd0, busy_w}, 32'd0);
        chk("reset_stall", {30'd0, stall_w}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // R-type flows EX -> MEM -> WB
        step(OP_R, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
        chk("rtype_ex_aluop", {29'd0, ex_op_w[0]}, 32'd3);
        chk("rtype_ex_alusrc", {31'd0, ex_src_w[0]}, 32'd0);
        idle(1);
        chk("rtype_mem_regwrite", {31'd0, mem_rw_w[0]}, 32'd1);
        idle(1);
        chk("rtype_wb", {30'd0, wb_rw_w[0], wb_m2r_w[0]}, 32'd2);
        idle(1);

        // Load-use: one bubble, dependent re-presented until it issues
        stall_cnt = 0;
        step(OP_LD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        step(OP_R, 1'b0, 1'b0, 5'd2, 5'd5, 5'd6);
        chk("lu_bubble_ex", {24'd0, ex_op_w[0], ex_rd_w[0]}, 32'd0);
        step(OP_R, 1'b0, 1'b0, 5'd2, 5'd5, 5'd6);
        chk("lu_dep_ex_rd", {27'd0, ex_rd_w[0]}, 32'd6);
        chk("lu_stall_cycles", stall_cnt, 32'd1);
        stall_cnt = 0;
        step(OP_LD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
        step(OP_R, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6);
        chk("lu_rd0_no_stall", stall_cnt, 32'd0);
        idle(3);

        // Store and branch
        step(OP_ST, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9);
        step(OP_BR, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10);
        chk("store_mem_memwrite", {31'd0, mem_mw_w[0]}, 32'd1);
        idle(1);
        chk("store_wb_regwrite", {31'd0, wb_rw_w[0]}, 32'd0);
        chk("branch_mem", {30'd0, mem_mw_w[0], mem_rw_w[0]}, 32'd0);
        idle(2);

        // Single multiply
        busy_cnt = '{0, 0};
        step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd7);
        idle(6);
        chk("mul_busy_lat4", busy_cnt[0], 32'd3);
        chk("mul_busy_lat1", busy_cnt[1], 32'd0);

        // Multiply in EX, load then dependent waiting in ID
        step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd2);
        for (int i = 0; i < 4; i++) step(OP_LD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd4);
        for (int i = 0; i < 2; i++) step(OP_R, 1'b0, 1'b0, 5'd4, 5'd3, 5'd8);
        idle(4);

        // Back-to-back multiplies
        busy_cnt = '{0, 0};
        step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd11);
        for (int i = 0; i < 4; i++) step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd12);
        idle(5);
        chk("b2b_busy_lat4", busy_cnt[0], 32'd6);

        // NoOp with a load opcode behind a live load
        step(OP_LD, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        step(OP_LD, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5);
        chk("noop_zero_ex", {27'd0, ex_rd_w[0]}, 32'd0);
        idle(3);

        // Reset dropped mid-hold
        step(OP_R, 1'b1, 1'b0, 5'd1, 5'd2, 5'd13);
        idle(1);
        rst_i = 1'b0;
        #1;
        model_reset();
        chk("midbusy_rst_busy", {30'd0, busy_w}, 32'd0);
        check_all_regs("midbusy_rst");
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        idle(1);

        // Randomized stream with small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [6:0] o;
            o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            step(o, 1'($urandom), ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined control unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and inserts bubbles for them. It also holds EX for a parametrised number of cycles on multiply instructions. It replaces the purely combinational decoder plus the hand-built control fields in the pipeline registers.

## Interface
- `MUL_LAT`, default 4: cycles a multiply occupies EX. Legal range is 1..16; 1 means no hold.
- `REG_W`, default 5: register address width.
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `Op_i` input 7: ID-stage opcode.
- `Mul_i` input 1: ID-stage funct7[0] qualifier. It only has meaning when `Op_i[6:4]`=011.
- `NoOp_i` input 1: forces the ID bundle to all-zero, i.e. a bubble.
- `Rs1Addr_i`, `Rs2Addr_i` input REG_W: ID-stage source registers.
- `RdAddr_i` input REG_W: ID-stage destination register.
- `Branch_o` output 1: ID-stage branch, combinational.
- `Stall_o` output 1: load-use stall, combinational. It deasserts PC write and IF/ID write.
- `Busy_o` output 1: multiply hold, combinational. It freezes PC, IF/ID and ID/EX.
- `EX_ALUOp_o` output 3, `EX_ALUSrc_o` output 1, `EX_Mul_o` output 1, `EX_RdAddr_o` output REG_W: ID/EX bundle.
- `MEM_MemRead_o`, `MEM_MemWrite_o`, `MEM_RegWrite_o` output 1, `MEM_RdAddr_o` output REG_W: EX/MEM bundle.
- `WB_RegWrite_o`, `WB_MemtoReg_o` output 1, `WB_RdAddr_o` output REG_W: MEM/WB bundle.

## Operation
- Decode rules. The ID bundle is all-zero when `NoOp_i`=1. Otherwise:
  - Branch = Op[6].
  - ALUSrc = ~Op[5] | ~Op[4].
  - ALUOp = Op[6:4].
  - MemWrite = ~Op[6] & Op[5] & ~Op[4].
  - MemRead = ~Op[5] & ~Op[4].
  - MemtoReg = MemRead.
  - RegWrite = ~Op[5] | Op[4].
  - Mul = Mul_i & (Op[6:4]==011).
- Load-use hazard. `Stall_o` = MEM-bound MemRead held in ID/EX & `EX_RdAddr_o`≠0 & (`EX_RdAddr_o`==`Rs1Addr_i` | `EX_RdAddr_o`==`Rs2Addr_i`) & ~`NoOp_i`.
- Multiply hold.
  - A counter `cnt` of width clog2(MUL_LAT)+1 resets to 0.
  - `Busy_o` = `EX_Mul_o` & (`cnt` ≠ MUL_LAT-1).
  - While `Busy_o`=1, `cnt` increments.
  - When `Busy_o`=0, `cnt` clears to 0.
  - A multiply therefore spends exactly MUL_LAT cycles in EX.
- Per-edge update priority:
  1. Reset. All registers and `cnt` are cleared.
  2. `Busy_o`=1:
     - ID/EX holds.
     - EX/MEM loads a bubble.
     - MEM/WB loads EX/MEM.
  3. `Stall_o`=1:
     - ID/EX loads a bubble. Its Rd is also cleared.
     - EX/MEM loads ID/EX.
     - MEM/WB loads EX/MEM.
  4. Normal:
     - ID/EX loads the ID bundle.
     - EX/MEM loads ID/EX.
     - MEM/WB loads EX/MEM.
- When busy and load-use coincide, busy wins. Load-use is re-evaluated once the multiply leaves EX. `Stall_o` is still driven combinationally during busy, but the front end is already frozen by `Busy_o`.
- A bubble is all control bits 0 and Rd 0. Bubbles never write registers or memory.
- MEM-bound bits travel ID/EX→EX/MEM. WB-bound bits travel ID/EX→EX/MEM→MEM/WB. Rd travels with them.

## Timing
- Reset (`rst_i`=0) takes effect immediately, without waiting for a clock edge. Every registered output is then 0 and `cnt` is 0. `Busy_o` and `Stall_o` are therefore 0.
- Combinational outputs from ID inputs: `Branch_o` and `Stall_o`. They are valid in the same cycle as the inputs.
- Control latency from the ID bundle:
  - EX outputs: 1 cycle.
  - MEM outputs: 2 cycles.
  - WB outputs: 3 cycles.
  - Each multiply hold adds MUL_LAT-1 cycles.
- Load-use costs exactly 1 bubble cycle. The dependent instruction issues from ID on the following edge.
- A multiply entering EX at edge N:
  - `Busy_o`=1 for cycles N..N+MUL_LAT-2.
  - It leaves EX at edge N+MUL_LAT-1.
  - MUL_LAT=1 gives zero hold cycles.
- Back-to-back multiplies:
  - `cnt` clears on the advancing edge.
  - The second multiply gets its full MUL_LAT cycles in EX.
  - No idle cycle is inserted between them.
- Reset asserted mid-hold aborts the multiply and clears `cnt` and all bundles. After release the pipeline starts empty.

## Test plan
- Reset, then release and apply R-type `Op_i`=0110011 → the bundle appears in stages on consecutive cycles:
  - Cycle +1: EX_ALUOp=011, EX_ALUSrc=0.
  - Cycle +2: MEM_RegWrite=1.
  - Cycle +3: WB_RegWrite=1, WB_MemtoReg=0.
  - All outputs are 0 during reset.
- Load `Op_i`=0000011 with Rd=5, then an R-type with Rs2=5 → `Stall_o`=1 for exactly 1 cycle, with the following bubble:
  - One cycle later, EX shows ALUOp=000 and Rd=0.
  - The dependent instruction then reaches EX.
  - The same sequence with Rd=0 gives no stall.
- Store 0100011 and branch 1100011 → for the store, MEM_MemWrite=1 and WB_RegWrite=0. For the branch, `Branch_o`=1 combinationally with RegWrite and MemWrite 0.
- Multiply (Op=0110011, Mul_i=1, MUL_LAT=4) → `Busy_o` high for 3 cycles and EX_Mul held. During the hold, EX/MEM shows bubbles. Then the multiply advances. Repeat with MUL_LAT=1 to confirm no busy.
- Multiply in EX while ID holds a load-dependent instruction → busy is served first, then the load-use check is re-evaluated. Also: two back-to-back multiplies → 3+3 busy cycles with no gap.
- `NoOp_i`=1 with a load opcode → zero bundle and no stall. Also: `rst_i` dropped mid-busy → `Busy_o` and `cnt` cleared immediately, and the pipeline is empty after release.
